// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes,
// skip-condition codes and the sequencer state encoding.
package acc_cpu_pkg;

  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUB      = 4'h4;
  localparam logic [3:0] OP_HALT     = 4'h7;
  localparam logic [3:0] OP_SKIPCOND = 4'h8;
  localparam logic [3:0] OP_JUMP     = 4'h9;
  localparam logic [3:0] OP_CLEAR    = 4'hA;

  // SKIPCOND operand byte, low two bits
  localparam logic [1:0] SKC_NEG   = 2'b00;
  localparam logic [1:0] SKC_ZERO  = 2'b01;
  localparam logic [1:0] SKC_POS   = 2'b10;
  localparam logic [1:0] SKC_NEVER = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    FETCH_ARG = 3'd2,
    DECODE    = 3'd3,
    EXEC_RD   = 3'd4,
    EXEC_ALU  = 3'd5,
    EXEC_WR   = 3'd6,
    HALTED    = 3'd7
  } state_t;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: computes the next AC for LOAD/ADD/SUB
// and evaluates the SKIPCOND condition against the current AC.
import acc_cpu_pkg::*;

module acc_cpu_alu (
  input  logic [3:0] op,
  input  logic [7:0] ac,
  input  logic [7:0] mbr,
  input  logic [1:0] skc,
  output logic [7:0] result,
  output logic       skip
);

  // Arithmetic wraps mod 256; no flags are kept.
  always_comb begin
    result = ac;
    case (op)
      OP_LOAD: result = mbr;
      OP_ADD:  result = ac + mbr;
      OP_SUB:  result = ac - mbr;
      default: result = ac;
    endcase
  end

  // Skip condition on AC, treating AC as two's complement.
  always_comb begin
    skip = 1'b0;
    case (skc)
      SKC_NEG:   skip = ac[7];
      SKC_ZERO:  skip = (ac == 8'h00);
      SKC_POS:   skip = !ac[7] && (ac != 8'h00);
      SKC_NEVER: skip = 1'b0;
      default:   skip = 1'b0;
    endcase
  end

endmodule

// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator CPU.
// Owns PC, IR, MAR, MBR and AC and drives a single-port memory through
// a req/ready handshake. Memory outputs are decoded from registered
// state only, so they hold steady through wait states and drop at once
// when reset is asserted.
//
// state     | meaning
// IDLE      | waiting for start after reset
// FETCH_OP  | read opcode byte at pc
// FETCH_ARG | read operand byte at pc into MAR
// DECODE    | dispatch on IR[7:4], no memory request
// EXEC_RD   | read operand data at MAR into MBR
// EXEC_ALU  | update AC from MBR
// EXEC_WR   | write AC to MAR
// HALTED    | stopped by HALT or illegal opcode, waiting for start
import acc_cpu_pkg::*;

module acc_cpu_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [7:0]        ac,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] mar;
  logic [7:0]        mbr;
  logic [7:0]        alu_result;
  logic              alu_skip;

  acc_cpu_alu u_alu (
    .op     (ir[7:4]),
    .ac     (ac),
    .mbr    (mbr),
    .skc    (mar[1:0]),
    .result (alu_result),
    .skip   (alu_skip)
  );

  // Memory interface decoded from the current state.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (state)
      FETCH_OP, FETCH_ARG: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      EXEC_RD: begin
        mem_req  = 1'b1;
        mem_addr = mar;
      end
      EXEC_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = mar;
        mem_wdata = ac;
      end
      default: ;
    endcase
  end

  // Status flags.
  always_comb begin
    busy   = (state != IDLE) && (state != HALTED);
    halted = (state == HALTED);
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= 8'h00;
      mar     <= '0;
      mbr     <= 8'h00;
      ac      <= 8'h00;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= RESET_PC;
            state <= FETCH_OP;
          end
        end
        FETCH_OP: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= FETCH_ARG;
          end
        end
        FETCH_ARG: begin
          if (mem_ready) begin
            mar   <= ADDR_W'(mem_rdata);
            pc    <= pc + ADDR_W'(1);
            state <= DECODE;
          end
        end
        DECODE: begin
          case (ir[7:4])
            OP_LOAD, OP_ADD, OP_SUB: state <= EXEC_RD;
            OP_STORE:                state <= EXEC_WR;
            OP_JUMP: begin
              pc    <= mar;
              state <= FETCH_OP;
            end
            OP_CLEAR: begin
              ac    <= 8'h00;
              state <= FETCH_OP;
            end
            OP_SKIPCOND: begin
              if (alu_skip) pc <= pc + ADDR_W'(2);
              state <= FETCH_OP;
            end
            OP_HALT: state <= HALTED;
            default: begin
              illegal <= 1'b1;
              state   <= HALTED;
            end
          endcase
        end
        EXEC_RD: begin
          if (mem_ready) begin
            mbr   <= mem_rdata;
            state <= EXEC_ALU;
          end
        end
        EXEC_ALU: begin
          ac    <= alu_result;
          state <= FETCH_OP;
        end
        EXEC_WR: begin
          if (mem_ready) state <= FETCH_OP;
        end
        HALTED: begin
          // AC is deliberately kept across a restart.
          if (start) begin
            illegal <= 1'b0;
            pc      <= RESET_PC;
            state   <= FETCH_OP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Self-checking bench for acc_cpu_sequencer. An instruction-level model
// of the program predicts every memory access, the final AC/PC/illegal
// state and the number of busy cycles; a single negedge process plays
// the memory (with configurable wait states) and checks each access.
module tb_acc_cpu_sequencer;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic [7:0] ac, pc;
  logic       busy, halted, illegal;

  logic [7:0] mem [256];
  logic [7:0] mm  [256];
  acc_t       exp_q[$];

  int         vecs = 0;
  int         errs = 0;
  int         waits = 0;
  bit         junk_ready = 1'b0;
  int         wcnt = 0;
  int         writes = 0;
  logic [7:0] r_addr, r_wdata;
  logic       r_we;

  logic [7:0] m_ac = 8'h00;
  logic [7:0] exp_pc;
  logic       exp_illegal;
  int         exp_cycles;
  int         cyc;

  acc_cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ac(ac), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic void push(input logic we, input logic [7:0] addr, input logic [7:0] data);
    acc_t e;
    e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endfunction

  // Instruction-level execution of the program in mm[] from address 0.
  task automatic model_run(input int w);
    logic [7:0] p, op, arg, v;
    bit stop, take;
    p = 8'h00; stop = 0; exp_cycles = 0; exp_illegal = 1'b0;
    for (int n = 0; n < 100 && !stop; n++) begin
      op = mm[p];  push(1'b0, p, 8'h00); p = p + 8'd1;
      arg = mm[p]; push(1'b0, p, 8'h00); p = p + 8'd1;
      exp_cycles += 2 * (w + 1) + 1;
      case (op[7:4])
        4'h1, 4'h3, 4'h4: begin
          push(1'b0, arg, 8'h00);
          v = mm[arg];
          exp_cycles += w + 2;
          if (op[7:4] == 4'h1)      m_ac = v;
          else if (op[7:4] == 4'h3) m_ac = m_ac + v;
          else                      m_ac = m_ac - v;
        end
        4'h2: begin
          push(1'b1, arg, m_ac);
          mm[arg] = m_ac;
          exp_cycles += w + 1;
        end
        4'h7: stop = 1;
        4'h8: begin
          case (arg[1:0])
            2'd0:    take = ($signed(m_ac) < 0);
            2'd1:    take = (m_ac == 8'h00);
            2'd2:    take = ($signed(m_ac) > 0);
            default: take = 0;
          endcase
          if (take) p = p + 8'd2;
        end
        4'h9: p = arg;
        4'hA: m_ac = 8'h00;
        default: begin
          exp_illegal = 1'b1;
          stop = 1;
        end
      endcase
    end
    exp_pc = p;
  endtask

  // Memory responder and access checker.
  always @(negedge clk) begin
    acc_t e;
    if (mem_req) begin
      if (wcnt == 0) begin
        r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata;
      end else begin
        chk("hold_addr", mem_addr, r_addr);
        chk("hold_we", mem_we, r_we);
        chk("hold_wdata", mem_wdata, r_wdata);
      end
      if (wcnt >= waits) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        if (exp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL extra_access: got addr %0h we %0b expected no access", mem_addr, mem_we);
        end else begin
          e = exp_q.pop_front();
          chk("acc_we", mem_we, e.we);
          chk("acc_addr", mem_addr, e.addr);
          if (e.we) chk("acc_wdata", mem_wdata, e.data);
        end
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          writes++;
        end
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = junk_ready;
      mem_rdata = 8'h00;
      wcnt = 0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Runs the program in mem[] from a start pulse until HALTED.
  task automatic run_prog(input int w, input bit extra_start, input bit junk,
                          input bit restart_chk, input logic [7:0] keep_ac);
    bit done;
    waits = w; junk_ready = junk;
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    model_run(w);
    @(negedge clk); start = 1'b1;
    cyc = 0; done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      start = extra_start && (cyc == 4);
      if (restart_chk && k == 0) begin
        chk("restart_illegal", illegal, 1'b0);
        chk("restart_pc", pc, 8'h00);
        chk("restart_ac", ac, keep_ac);
      end
      if (halted) done = 1;
      else if (busy) cyc++;
    end
    start = 1'b0;
    junk_ready = 1'b0;
    chk("reached_halt", done, 1'b1);
    chk("busy_cycles", cyc, exp_cycles);
    chk("final_ac", ac, m_ac);
    chk("final_pc", pc, exp_pc);
    chk("final_illegal", illegal, exp_illegal);
    chk("all_accesses_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int seen;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_ac", ac, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    reset = 1'b0;
    m_ac = 8'h00;

    // LOAD 20, HALT; zero-wait with ready toggling while idle.
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h20; mem[8'h02] = 8'h70; mem[8'h03] = 8'h00;
    mem[8'h20] = 8'h5A;
    run_prog(0, 0, 1, 0, 8'h00);
    chk("t1_ac", ac, 8'h5A);
    chk("t1_pc", pc, 8'h04);
    chk("t1_halted", halted, 1'b1);
    chk("t1_cycles", cyc, 8);

    // LOAD/ADD/STORE/HALT with two wait states; sum wraps.
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h20; mem[8'h02] = 8'h30; mem[8'h03] = 8'h21;
    mem[8'h04] = 8'h20; mem[8'h05] = 8'h22; mem[8'h06] = 8'h70; mem[8'h07] = 8'h00;
    mem[8'h20] = 8'hF0; mem[8'h21] = 8'h20;
    writes = 0;
    run_prog(2, 0, 0, 0, 8'h00);
    chk("t2_mem22", mem[8'h22], 8'h10);
    chk("t2_writes", writes, 1);

    // CLEAR, SKIPCOND zero (taken), JUMP 40, HALT at 40.
    clear_mem();
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'h00; mem[8'h02] = 8'h80; mem[8'h03] = 8'h01;
    mem[8'h04] = 8'h70; mem[8'h05] = 8'h00; mem[8'h06] = 8'h90; mem[8'h07] = 8'h40;
    mem[8'h40] = 8'h70; mem[8'h41] = 8'h00;
    run_prog(1, 0, 0, 0, 8'h00);
    chk("t3_pc", pc, 8'h42);
    chk("t3_ac", ac, 8'h00);

    // SKIPCOND zero with ac=1: not taken, halts in the slot.
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h30; mem[8'h30] = 8'h01;
    run_prog(0, 0, 0, 0, 8'h00);
    chk("t4_pc", pc, 8'h06);

    // ac=FF: negative skip taken, positive and never not taken.
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h30; mem[8'h02] = 8'h80; mem[8'h03] = 8'h00;
    mem[8'h04] = 8'h70; mem[8'h05] = 8'h00; mem[8'h06] = 8'h80; mem[8'h07] = 8'h02;
    mem[8'h08] = 8'h80; mem[8'h09] = 8'h03; mem[8'h0A] = 8'h70; mem[8'h0B] = 8'h00;
    mem[8'h30] = 8'hFF;
    run_prog(0, 0, 0, 0, 8'h00);
    chk("t5_pc", pc, 8'h0C);

    // ac=05: positive skip taken, negative not taken.
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h30; mem[8'h02] = 8'h80; mem[8'h03] = 8'h02;
    mem[8'h04] = 8'h70; mem[8'h05] = 8'h00; mem[8'h06] = 8'h80; mem[8'h07] = 8'h00;
    mem[8'h08] = 8'h70; mem[8'h09] = 8'h00;
    mem[8'h30] = 8'h05;
    run_prog(0, 0, 0, 0, 8'h00);
    chk("t6_pc", pc, 8'h0A);
    chk("t6_ac", ac, 8'h05);

    // Illegal opcode F3, then restart from HALTED keeps ac.
    clear_mem();
    mem[8'h00] = 8'hF3; mem[8'h01] = 8'h00;
    run_prog(0, 0, 0, 0, 8'h00);
    chk("t7_illegal", illegal, 1'b1);
    chk("t7_pc", pc, 8'h02);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7_no_req", mem_req, 1'b0);
    end
    run_prog(0, 0, 0, 1, 8'h05);

    // Reset asserted in an EXEC_WR wait state.
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h30; mem[8'h02] = 8'h20; mem[8'h03] = 8'h50;
    mem[8'h04] = 8'h70; mem[8'h05] = 8'h00; mem[8'h30] = 8'h77;
    waits = 3;
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    model_run(3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && seen < 2; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) seen++;
    end
    chk("t8_reached_wr_wait", seen, 2);
    #1 reset = 1'b1;
    #1;
    chk("t8_req_drop", mem_req, 1'b0);
    chk("t8_busy", busy, 1'b0);
    chk("t8_ac", ac, 8'h00);
    chk("t8_pc", pc, 8'h00);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ac = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t8_no_req", mem_req, 1'b0);
    end
    chk("t8_addr", mem_addr, 8'h00);
    chk("t8_halted", halted, 1'b0);
    chk("t8_mem50", mem[8'h50], 8'h00);

    // Operand at FF wraps next fetch to 00; extra start while busy.
    clear_mem();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h10; mem[8'h02] = 8'h90; mem[8'h03] = 8'hFE;
    mem[8'hFE] = 8'h20; mem[8'hFF] = 8'h00; mem[8'h10] = 8'h70;
    run_prog(1, 1, 0, 0, 8'h00);
    chk("t9_pc", pc, 8'h02);
    chk("t9_ac", ac, 8'h70);
    chk("t9_mem00", mem[8'h00], 8'h70);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
